// File: rtl/io_stream_controller_if.sv
// Pin-side stream, memory-port and core-handshake bundle of io_stream_controller.
// The controller uses the master view; the pads, memories and core use the slave view.
interface io_stream_controller_if #(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 8,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [IN_WIDTH-1:0]   in_data;
   logic                  in_vld;
   logic                  in_rdy;
   logic [OUT_WIDTH-1:0]  out_data;
   logic                  out_vld;
   logic                  out_rdy;
   logic                  instr_wen;
   logic [ADDR_WIDTH-1:0] instr_wadr;
   logic [WORD_WIDTH-1:0] instr_wdata;
   logic                  data_wen;
   logic [ADDR_WIDTH-1:0] data_wadr;
   logic [WORD_WIDTH-1:0] data_wdata;
   logic                  data_ren;
   logic [ADDR_WIDTH-1:0] data_radr;
   logic [WORD_WIDTH-1:0] data_rdata;
   logic                  core_start;
   logic                  core_done;

   modport master (
      input  in_data, in_vld, out_rdy, data_rdata, core_done,
      output in_rdy, out_data, out_vld,
             instr_wen, instr_wadr, instr_wdata,
             data_wen, data_wadr, data_wdata,
             data_ren, data_radr, core_start
   );

   modport slave (
      output in_data, in_vld, out_rdy, data_rdata, core_done,
      input  in_rdy, out_data, out_vld,
             instr_wen, instr_wadr, instr_wdata,
             data_wen, data_wadr, data_wdata,
             data_ren, data_radr, core_start
   );
endinterface

// File: rtl/io_stream_controller.sv
// Pad-side stream controller: loads header, instructions and input frames from narrow
// beats, starts the core, then streams result words back out as narrow beats.
module io_stream_controller #(
   parameter int IN_WIDTH    = 16,
   parameter int OUT_WIDTH   = 8,
   parameter int WORD_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int NUM_CONFIGS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reload,
   io_stream_controller_if.master io,
   output logic [ADDR_WIDTH-1:0] instr_max_wadr,
   output logic [ADDR_WIDTH-1:0] input_max_wadr,
   output logic [ADDR_WIDTH-1:0] input_wadr_offset,
   output logic [ADDR_WIDTH-1:0] output_max_adr,
   output logic [ADDR_WIDTH-1:0] output_adr_offset,
   output logic [15:0]           frame_cnt,
   output logic [2:0]            state
);
   localparam int BEATS_IN  = WORD_WIDTH / IN_WIDTH;
   localparam int BEATS_OUT = WORD_WIDTH / OUT_WIDTH;
   localparam int BI_W      = (BEATS_IN  > 1) ? $clog2(BEATS_IN)  : 1;
   localparam int BO_W      = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;

   localparam logic [2:0] ST_CFG    = 3'd0;
   localparam logic [2:0] ST_INSTR  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_UNLOAD = 3'd4;

   // Header slots in arrival order.
   localparam int C_INSTR_MAX = 0;
   localparam int C_INPUT_MAX = 1;
   localparam int C_INPUT_OFF = 2;
   localparam int C_OUT_MAX   = 3;
   localparam int C_OUT_OFF   = 4;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cfg_q [NUM_CONFIGS];
   logic [ADDR_WIDTH-1:0] cfg_d [NUM_CONFIGS];
   logic [2:0]            cfg_idx_q, cfg_idx_d;
   logic [BI_W-1:0]       ibeat_q, ibeat_d;
   logic [WORD_WIDTH-1:0] word_buf_q, word_buf_d;
   logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
   logic                  in_rdy_q, in_rdy_d;
   logic                  instr_wen_q, instr_wen_d;
   logic [ADDR_WIDTH-1:0] instr_wadr_q, instr_wadr_d;
   logic [WORD_WIDTH-1:0] instr_wdata_q, instr_wdata_d;
   logic                  data_wen_q, data_wen_d;
   logic [ADDR_WIDTH-1:0] data_wadr_q, data_wadr_d;
   logic [WORD_WIDTH-1:0] data_wdata_q, data_wdata_d;
   logic                  core_start_q, core_start_d;
   logic                  data_ren_q, data_ren_d;
   logic [ADDR_WIDTH-1:0] data_radr_q, data_radr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  out_vld_q, out_vld_d;
   logic [WORD_WIDTH-1:0] out_shift_q, out_shift_d;
   logic [BO_W-1:0]       obeat_q, obeat_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;

   logic                  in_acc;
   logic                  out_acc;
   logic                  ibeat_last;
   logic                  obeat_last;
   logic [WORD_WIDTH-1:0] asm_word;

   assign in_acc     = io.in_vld && in_rdy_q;
   assign out_acc    = out_vld_q && io.out_rdy;
   assign ibeat_last = (ibeat_q == BI_W'(BEATS_IN - 1));
   assign obeat_last = (obeat_q == BO_W'(BEATS_OUT - 1));

   // Partial word with the current beat dropped into its slot, LSB beat first.
   always_comb begin
      asm_word = word_buf_q;
      for (int k = 0; k < BEATS_IN; k++) begin
         if (ibeat_q == BI_W'(k)) begin
            asm_word[k*IN_WIDTH +: IN_WIDTH] = io.in_data;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cfg_d         = cfg_q;
      cfg_idx_d     = cfg_idx_q;
      ibeat_d       = ibeat_q;
      word_buf_d    = word_buf_q;
      word_idx_d    = word_idx_q;
      instr_wen_d   = 1'b0;
      instr_wadr_d  = instr_wadr_q;
      instr_wdata_d = instr_wdata_q;
      data_wen_d    = 1'b0;
      data_wadr_d   = data_wadr_q;
      data_wdata_d  = data_wdata_q;
      core_start_d  = 1'b0;
      data_ren_d    = 1'b0;
      data_radr_d   = data_radr_q;
      rd_pend_d     = data_ren_q;
      out_vld_d     = out_vld_q;
      out_shift_d   = out_shift_q;
      obeat_d       = obeat_q;
      frame_cnt_d   = frame_cnt_q;

      case (state_q)
         ST_CFG: begin
            if (in_acc) begin
               cfg_d[cfg_idx_q] = io.in_data[ADDR_WIDTH-1:0];
               if (cfg_idx_q == 3'(NUM_CONFIGS - 1)) begin
                  cfg_idx_d = 3'd0;
                  state_d   = ST_INSTR;
               end else begin
                  cfg_idx_d = cfg_idx_q + 3'd1;
               end
            end
         end
         ST_INSTR: begin
            if (in_acc) begin
               word_buf_d = asm_word;
               if (ibeat_last) begin
                  ibeat_d       = '0;
                  instr_wen_d   = 1'b1;
                  instr_wadr_d  = word_idx_q;
                  instr_wdata_d = asm_word;
                  if (word_idx_q == cfg_q[C_INSTR_MAX]) begin
                     word_idx_d = '0;
                     state_d    = ST_DATA;
                  end else begin
                     word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                  end
               end else begin
                  ibeat_d = ibeat_q + BI_W'(1);
               end
            end
         end
         ST_DATA: begin
            if (in_acc) begin
               word_buf_d = asm_word;
               if (ibeat_last) begin
                  ibeat_d      = '0;
                  data_wen_d   = 1'b1;
                  data_wadr_d  = cfg_q[C_INPUT_OFF] + word_idx_q;
                  data_wdata_d = asm_word;
                  if (word_idx_q == cfg_q[C_INPUT_MAX]) begin
                     word_idx_d   = '0;
                     core_start_d = 1'b1;
                     state_d      = ST_RUN;
                  end else begin
                     word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                  end
               end else begin
                  ibeat_d = ibeat_q + BI_W'(1);
               end
            end
         end
         ST_RUN: begin
            if (io.core_done) begin
               word_idx_d  = '0;
               data_ren_d  = 1'b1;
               data_radr_d = cfg_q[C_OUT_OFF];
               state_d     = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            // Read data arrives the cycle after data_ren; rd_pend marks that cycle.
            if (rd_pend_q) begin
               out_shift_d = io.data_rdata;
               out_vld_d   = 1'b1;
               obeat_d     = '0;
            end else if (out_acc) begin
               if (obeat_last) begin
                  out_vld_d = 1'b0;
                  obeat_d   = '0;
                  if (word_idx_q == cfg_q[C_OUT_MAX]) begin
                     word_idx_d  = '0;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     state_d     = ST_DATA;
                  end else begin
                     word_idx_d  = word_idx_q + ADDR_WIDTH'(1);
                     data_ren_d  = 1'b1;
                     data_radr_d = cfg_q[C_OUT_OFF] + word_idx_q + ADDR_WIDTH'(1);
                  end
               end else begin
                  out_shift_d = out_shift_q >> OUT_WIDTH;
                  obeat_d     = obeat_q + BO_W'(1);
               end
            end
         end
         default: state_d = ST_CFG;
      endcase

      in_rdy_d = (state_d == ST_CFG) || (state_d == ST_INSTR) || (state_d == ST_DATA);
   end

   // reload is a soft reset and clears exactly what rst clears.
   always_ff @(posedge clk) begin
      if (rst || reload) begin
         state_q       <= ST_CFG;
         for (int i = 0; i < NUM_CONFIGS; i++) begin
            cfg_q[i] <= '0;
         end
         cfg_idx_q     <= 3'd0;
         ibeat_q       <= '0;
         word_buf_q    <= '0;
         word_idx_q    <= '0;
         in_rdy_q      <= 1'b0;
         instr_wen_q   <= 1'b0;
         instr_wadr_q  <= '0;
         instr_wdata_q <= '0;
         data_wen_q    <= 1'b0;
         data_wadr_q   <= '0;
         data_wdata_q  <= '0;
         core_start_q  <= 1'b0;
         data_ren_q    <= 1'b0;
         data_radr_q   <= '0;
         rd_pend_q     <= 1'b0;
         out_vld_q     <= 1'b0;
         out_shift_q   <= '0;
         obeat_q       <= '0;
         frame_cnt_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         cfg_q         <= cfg_d;
         cfg_idx_q     <= cfg_idx_d;
         ibeat_q       <= ibeat_d;
         word_buf_q    <= word_buf_d;
         word_idx_q    <= word_idx_d;
         in_rdy_q      <= in_rdy_d;
         instr_wen_q   <= instr_wen_d;
         instr_wadr_q  <= instr_wadr_d;
         instr_wdata_q <= instr_wdata_d;
         data_wen_q    <= data_wen_d;
         data_wadr_q   <= data_wadr_d;
         data_wdata_q  <= data_wdata_d;
         core_start_q  <= core_start_d;
         data_ren_q    <= data_ren_d;
         data_radr_q   <= data_radr_d;
         rd_pend_q     <= rd_pend_d;
         out_vld_q     <= out_vld_d;
         out_shift_q   <= out_shift_d;
         obeat_q       <= obeat_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign io.in_rdy      = in_rdy_q;
   assign io.out_vld     = out_vld_q;
   assign io.out_data    = out_shift_q[OUT_WIDTH-1:0];
   assign io.instr_wen   = instr_wen_q;
   assign io.instr_wadr  = instr_wadr_q;
   assign io.instr_wdata = instr_wdata_q;
   assign io.data_wen    = data_wen_q;
   assign io.data_wadr   = data_wadr_q;
   assign io.data_wdata  = data_wdata_q;
   assign io.data_ren    = data_ren_q;
   assign io.data_radr   = data_radr_q;
   assign io.core_start  = core_start_q;

   assign instr_max_wadr    = cfg_q[C_INSTR_MAX];
   assign input_max_wadr    = cfg_q[C_INPUT_MAX];
   assign input_wadr_offset = cfg_q[C_INPUT_OFF];
   assign output_max_adr    = cfg_q[C_OUT_MAX];
   assign output_adr_offset = cfg_q[C_OUT_OFF];
   assign frame_cnt         = frame_cnt_q;
   assign state             = state_q;
endmodule

// File: tb/tb_io_stream_controller.sv
// Scoreboard bench for io_stream_controller: expectations queued with stimulus,
// monitors queue observed writes/beats, scenario tasks compare them.
module tb_io_stream_controller;
   localparam int IW = 16;
   localparam int OW = 8;
   localparam int WW = 32;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          reload;
   logic [AW-1:0] instr_max_wadr, input_max_wadr, input_wadr_offset;
   logic [AW-1:0] output_max_adr, output_adr_offset;
   logic [15:0]   frame_cnt;
   logic [2:0]    state;

   int errors = 0;
   int checks = 0;

   logic [47:0] exp_instr[$], obs_instr[$], exp_data[$], obs_data[$];
   logic [7:0]  exp_beat[$], obs_beat[$];
   int          obs_gap[$];
   logic        start_with_wen[$];
   int          gap_run = 0;
   int          start_cnt = 0;
   bit          mem_const = 1'b1;

   io_stream_controller_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) io();

   io_stream_controller #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_CONFIGS(5)
   ) dut (
      .clk(clk), .rst(rst), .reload(reload), .io(io),
      .instr_max_wadr(instr_max_wadr), .input_max_wadr(input_max_wadr),
      .input_wadr_offset(input_wadr_offset), .output_max_adr(output_max_adr),
      .output_adr_offset(output_adr_offset), .frame_cnt(frame_cnt), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      return mem_const ? 32'h04030201 : {a ^ 16'hA5C3, a};
   endfunction

   // Data memory read port: one cycle of latency.
   always @(posedge clk) begin
      if (io.data_ren) io.data_rdata <= mem_rd(io.data_radr);
   end

   always @(negedge clk) begin
      if (io.instr_wen) obs_instr.push_back({io.instr_wadr, io.instr_wdata});
      if (io.data_wen) obs_data.push_back({io.data_wadr, io.data_wdata});
      if (io.core_start) begin
         start_cnt++;
         start_with_wen.push_back(io.data_wen);
      end
      if (io.out_vld && io.out_rdy) obs_beat.push_back(io.out_data);
      if (io.out_vld) begin
         if (gap_run > 0) obs_gap.push_back(gap_run);
         gap_run = 0;
      end else if (state == 3'd4) begin
         gap_run++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] v);
      int n = 0;
      io.in_data = v;
      io.in_vld  = 1'b1;
      while (!io.in_rdy) begin
         tick();
         n++;
         if (n > 100) begin
            $display("FAIL send_beat_timeout in_rdy=%0b required=1 state=%0d", io.in_rdy, state);
            $fatal(1, "input handshake never completed");
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; reload = 1'b0;
      io.in_vld = 1'b0; io.in_data = '0; io.out_rdy = 1'b1; io.core_done = 1'b0;
      tick(); tick();
      checks++; if (io.in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got=%0b exp=0", io.in_rdy); end
      checks++; if (io.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%0b exp=0", io.out_vld); end
      checks++; if (io.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", io.out_data); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
      checks++;
      if ({io.instr_wen, io.data_wen, io.data_ren, io.core_start} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes got=%b exp=0000", {io.instr_wen, io.data_wen, io.data_ren, io.core_start});
      end
      checks++;
      if ({instr_max_wadr, input_max_wadr, input_wadr_offset, output_max_adr, output_adr_offset} !== 80'h0) begin
         errors++; $display("FAIL reset_config got=nonzero exp=0");
      end
      checks++;
      if ({io.instr_wadr, io.data_wadr, io.data_radr, io.instr_wdata, io.data_wdata} !== 112'h0) begin
         errors++; $display("FAIL reset_addr_wdata got=nonzero exp=0");
      end
      rst = 1'b0;
      tick();
      checks++; if (io.in_rdy !== 1'b1) begin errors++; $display("FAIL in_rdy_rise got=%0b exp=1", io.in_rdy); end
   endtask

   task automatic test_config(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] e);
      send_beat(a); send_beat(b); send_beat(c); send_beat(d); send_beat(e);
      io.in_vld = 1'b0;
      checks++; if (instr_max_wadr !== a) begin errors++; $display("FAIL cfg_instr_max got=%h exp=%h", instr_max_wadr, a); end
      checks++; if (input_max_wadr !== b) begin errors++; $display("FAIL cfg_input_max got=%h exp=%h", input_max_wadr, b); end
      checks++; if (input_wadr_offset !== c) begin errors++; $display("FAIL cfg_input_off got=%h exp=%h", input_wadr_offset, c); end
      checks++; if (output_max_adr !== d) begin errors++; $display("FAIL cfg_output_max got=%h exp=%h", output_max_adr, d); end
      checks++; if (output_adr_offset !== e) begin errors++; $display("FAIL cfg_output_off got=%h exp=%h", output_adr_offset, e); end
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL cfg_to_instr got=%0d exp=1", state); end
   endtask

   // Leaves in_vld high so the data phase follows without a gap.
   task automatic test_instr(input int n);
      for (int i = 0; i < n; i++) begin
         exp_instr.push_back({16'(i), 32'hABCD1234});
         send_beat(16'h1234);
         send_beat(16'hABCD);
      end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL instr_to_data got=%0d exp=2", state); end
   endtask

   task automatic test_data(input int n, input logic [15:0] off, input logic [15:0] base);
      logic [15:0] lo;
      logic [47:0] e;
      logic [47:0] o;
      int s0;
      s0 = start_cnt;
      for (int i = 0; i < n; i++) begin
         lo = base + 16'(i);
         exp_data.push_back({off + 16'(i), ~lo, lo});
         send_beat(lo);
         send_beat(~lo);
      end
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL data_to_run got=%0d exp=3", state); end
      checks++; if (io.in_rdy !== 1'b0) begin errors++; $display("FAIL run_in_rdy got=%0b exp=0", io.in_rdy); end
      io.in_vld = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL core_start_pulses got=%0d exp=1", start_cnt - s0); end
      while (start_with_wen.size() > 0) begin
         checks++;
         if (start_with_wen.pop_front() !== 1'b1) begin errors++; $display("FAIL core_start_with_wen got=0 exp=1"); end
      end
      checks++;
      if (obs_instr.size() != exp_instr.size()) begin
         errors++; $display("FAIL instr_write_count got=%0d exp=%0d", obs_instr.size(), exp_instr.size());
      end
      while (exp_instr.size() > 0 && obs_instr.size() > 0) begin
         e = exp_instr.pop_front(); o = obs_instr.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL instr_write got=%h exp=%h", o, e); end
      end
      checks++;
      if (obs_data.size() != exp_data.size()) begin
         errors++; $display("FAIL data_write_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
      end
      while (exp_data.size() > 0 && obs_data.size() > 0) begin
         e = exp_data.pop_front(); o = obs_data.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL data_write got=%h exp=%h", o, e); end
      end
      exp_instr.delete(); obs_instr.delete(); exp_data.delete(); obs_data.delete();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL run_wait got=%0d exp=3", state); end
   endtask

   task automatic test_unload(input int n, input logic [15:0] off, input bit rnd, input logic [15:0] exp_frame);
      logic [31:0] w;
      logic [7:0]  held;
      logic [7:0]  e;
      logic [7:0]  o;
      bit          stall;
      int          cyc;
      int          g;
      stall = 1'b0; cyc = 0; held = '0;
      for (int j = 0; j < n; j++) begin
         w = mem_rd(off + 16'(j));
         for (int b = 0; b < 4; b++) exp_beat.push_back(w[b*8 +: 8]);
      end
      obs_gap.delete();
      io.core_done = 1'b1;
      tick();
      io.core_done = 1'b0;
      while (state != 3'd2 && cyc < 2000) begin
         if (stall) begin
            checks++;
            if (io.out_vld !== 1'b1 || io.out_data !== held) begin
               errors++; $display("FAIL stall_hold got=%0b/%h exp=1/%h", io.out_vld, io.out_data, held);
            end
         end
         io.out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = io.out_vld && !io.out_rdy;
         held  = io.out_data;
         tick();
         cyc++;
      end
      io.out_rdy = 1'b1;
      tick();
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL unload_done_state got=%0d exp=2", state); end
      checks++; if (io.in_rdy !== 1'b1) begin errors++; $display("FAIL unload_rearm_in_rdy got=%0b exp=1", io.in_rdy); end
      checks++;
      if (obs_beat.size() != exp_beat.size()) begin
         errors++; $display("FAIL beat_count got=%0d exp=%0d", obs_beat.size(), exp_beat.size());
      end
      while (exp_beat.size() > 0 && obs_beat.size() > 0) begin
         e = exp_beat.pop_front(); o = obs_beat.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL out_beat got=%h exp=%h", o, e); end
      end
      exp_beat.delete(); obs_beat.delete();
      checks++;
      if (obs_gap.size() != n) begin errors++; $display("FAIL bubble_count got=%0d exp=%0d", obs_gap.size(), n); end
      while (obs_gap.size() > 0) begin
         g = obs_gap.pop_front();
         checks++; if (g != 2) begin errors++; $display("FAIL bubble_len got=%0d exp=2", g); end
      end
      checks++; if (frame_cnt !== exp_frame) begin errors++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frame); end
   endtask

   task automatic test_reload_mid_word();
      reload = 1'b1; tick(); reload = 1'b0;
      tick();
      send_beat(16'd3); send_beat(16'd4); send_beat(16'h0010); send_beat(16'd2); send_beat(16'h0020);
      send_beat(16'h1234);
      io.in_vld = 1'b0;
      reload = 1'b1; tick(); reload = 1'b0;
      tick(); tick();
      checks++; if (obs_instr.size() != 0) begin errors++; $display("FAIL reload_instr_wen got=%0d exp=0", obs_instr.size()); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reload_state got=%0d exp=0", state); end
      checks++; if (input_max_wadr !== 16'd0) begin errors++; $display("FAIL reload_config got=%h exp=0", input_max_wadr); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reload_frame_cnt got=%0d exp=0", frame_cnt); end
      obs_instr.delete();
   endtask

   task automatic test_reload_mid_unload();
      int cyc = 0;
      io.core_done = 1'b1; tick(); io.core_done = 1'b0;
      while (!io.out_vld && cyc < 50) begin tick(); cyc++; end
      checks++; if (io.out_vld !== 1'b1) begin errors++; $display("FAIL mid_unload_vld got=%0b exp=1", io.out_vld); end
      reload = 1'b1; tick(); reload = 1'b0;
      checks++; if (io.out_vld !== 1'b0) begin errors++; $display("FAIL reload_out_vld got=%0b exp=0", io.out_vld); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reload_unload_state got=%0d exp=0", state); end
      checks++; if (io.in_rdy !== 1'b0) begin errors++; $display("FAIL reload_in_rdy got=%0b exp=0", io.in_rdy); end
      tick();
      checks++; if (io.in_rdy !== 1'b1) begin errors++; $display("FAIL reload_in_rdy_rise got=%0b exp=1", io.in_rdy); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reload_unload_frame got=%0d exp=0", frame_cnt); end
      exp_beat.delete(); obs_beat.delete(); obs_gap.delete();
   endtask

   initial begin
      test_reset();
      test_config(16'd125, 16'd23, 16'h07d0, 16'd23, 16'h07e8);
      test_instr(126);
      test_data(24, 16'h07d0, 16'h0100);
      mem_const = 1'b1;
      test_unload(24, 16'h07e8, 1'b0, 16'd1);
      test_reload_mid_word();
      test_config(16'd0, 16'd2, 16'hFFFE, 16'd5, 16'hFFFD);
      test_instr(1);
      test_data(3, 16'hFFFE, 16'h5000);
      mem_const = 1'b0;
      test_unload(6, 16'hFFFD, 1'b1, 16'd1);
      test_data(3, 16'hFFFE, 16'h6000);
      test_unload(6, 16'hFFFD, 1'b1, 16'd2);
      test_data(3, 16'hFFFE, 16'h7000);
      test_reload_mid_unload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/io_stream_controller.md
# io_stream_controller

Parametrised pad-side stream controller between the narrow user-IO pins and the accelerator core. It loads a configuration header, then instruction and input-data words assembled from `IN_WIDTH` beats, starts the core, and unloads results from data memory as `OUT_WIDTH` beats. After each unload it re-arms for the next input frame, keeping configuration and instructions, so multiple frames run without reloading.

## Interface
- `IN_WIDTH`, 16, input beat width.
- `OUT_WIDTH`, 8, output beat width.
- `WORD_WIDTH`, 32, memory word width; must be a multiple of both `IN_WIDTH` and `OUT_WIDTH`.
- `ADDR_WIDTH`, 16, memory address width; must be ≤ `IN_WIDTH`.
- `NUM_CONFIGS`, 5, fixed header length; only 5 is supported.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  IN_WIDTH  input beat.
- `in_vld`  in  1  input beat valid.
- `in_rdy`  out  1  controller accepts a beat.
- `out_data`  out  OUT_WIDTH  output beat.
- `out_vld`  out  1  output beat valid.
- `out_rdy`  in  1  sink accepts a beat.
- `instr_wen`  out  1  instruction memory write strobe.
- `instr_wadr`  out  ADDR_WIDTH  instruction memory write address.
- `instr_wdata`  out  WORD_WIDTH  instruction memory write data.
- `data_wen`  out  1  data memory write strobe.
- `data_wadr`  out  ADDR_WIDTH  data memory write address.
- `data_wdata`  out  WORD_WIDTH  data memory write data.
- `data_ren`  out  1  data memory read strobe.
- `data_radr`  out  ADDR_WIDTH  data memory read address.
- `data_rdata`  in  WORD_WIDTH  read data, valid 1 cycle after `data_ren`.
- `core_start`  out  1  one-cycle pulse that starts the core.
- `core_done`  in  1  core completion pulse.
- `reload`  in  1  soft reset; behaves identically to `rst`.
- `instr_max_wadr`, `input_max_wadr`, `input_wadr_offset`, `output_max_adr`, `output_adr_offset`  out  ADDR_WIDTH each  config registers, in header order.
- `frame_cnt`  out  16  count of completed unloads, wraps at 2^16.
- `state`  out  3  current FSM state.

## Operation
- States:
  - CFG=0: in_rdy=1.
  - INSTR=1: in_rdy=1.
  - DATA=2: in_rdy=1.
  - RUN=3: in_rdy=0.
  - UNLOAD=4: in_rdy=0.
- Handshake:
  - Input beat accepted when `in_vld && in_rdy`.
  - Output beat accepted when `out_vld && out_rdy`.
- CFG:
  - Each accepted beat goes to config register `cfg_idx`, in the order instr_max, input_max, input_off, output_max, output_off.
  - Low `ADDR_WIDTH` bits are kept; the rest are dropped.
  - After beat 4 → INSTR.
- INSTR / DATA word assembly:
  - Beat k of a word fills bits `[k*IN_WIDTH +: IN_WIDTH]`, LSB beat first.
  - `BEATS_IN = WORD_WIDTH/IN_WIDTH`. With `BEATS_IN=1`, every beat is a word.
- INSTR writes:
  - On the final beat of word i, the next cycle has `instr_wen=1`, `instr_wadr=i`, and the assembled word.
  - After word `instr_max_wadr` → DATA.
- DATA writes:
  - Same as INSTR, but `data_wen`, with `data_wadr = input_wadr_offset + i` (mod 2^ADDR_WIDTH).
  - After word `input_max_wadr` → RUN, with `core_start` pulsed on the cycle RUN is entered.
- RUN: waits for `core_done`, then → UNLOAD. `core_done` in any other state is ignored.
- UNLOAD, per word j = 0..`output_max_adr`:
  - Assert `data_ren` with `data_radr = output_adr_offset + j`.
  - Next cycle, latch `data_rdata` into the shift register and raise `out_vld`.
  - Emit `BEATS_OUT = WORD_WIDTH/OUT_WIDTH` beats LSB first, shifting on each handshake.
  - The cycle after the last beat's handshake, issue the next read.
  - After the last beat of word `output_max_adr`: `frame_cnt++`, → DATA with the word index cleared. CFG and INSTR contents are retained.

## Timing
- Reset values (`rst` or `reload`):
  - Outputs: `in_rdy=0`, `out_vld=0`, `out_data=0`, all strobes 0, addresses/wdata 0, config outputs 0, `frame_cnt=0`, `state=CFG`.
  - Internal: beat and word counters 0, partial word discarded.
  - `in_rdy` rises the first cycle after reset deasserts.
- Latencies:
  - Memory write strobes: 1 cycle after the final-beat handshake.
  - `core_start`: same cycle as the final `data_wen`.
- `reload` mid-word or mid-unload:
  - A write that would have issued the next cycle is suppressed.
  - `out_vld` drops the next cycle.
- Output stalls: `out_vld` and `out_data` hold while `out_rdy=0`.
- Output bubbles: exactly 2 cycles of `out_vld=0` between words. The last-beat handshake clears `out_vld`, the next cycle issues `data_ren`, and the cycle after that latches `data_rdata`.
- Boundary values:
  - max=0 → single word.
  - Offset+index wraps modulo 2^ADDR_WIDTH.
  - `in_vld` held high across the INSTR→DATA transition loses no beat.

## Test plan
- Header 125, 23, 0x7d0, 23, 0x7e8 → config outputs equal these values; state=INSTR after 5 beats.
- 126 instructions as 252 beats with 0x1234 then 0xABCD → `instr_wdata=0xABCD1234` at addresses 0..125; state=DATA.
- 24 data words → `data_wadr` 0x7d0..0x7e7; `core_start` is a single pulse on the cycle after the final beat; in_rdy=0 in RUN.
- `core_done`, with memory at 0x7e8 returning 0x04030201 and `out_rdy=1` → beats 01, 02, 03, 04 per word; 96 beats total; `frame_cnt=1`; state=DATA.
- `out_rdy` toggled randomly → no beat lost or duplicated; `out_data` stable during stalls.
- `reload` asserted after beat 1 of an instruction word → no `instr_wen`; state=CFG; a fresh header and second frame complete correctly; a second unload without reload gives `frame_cnt=2`.
